data_mem_arbiter: RTL

Two-requester arbiter that shares the single-ported 32-word data memory between a CPU load/store port (requester 0) and a secondary master such as a DMA or debug port (requester 1). It accepts request/grant handshakes, applies round-robin priority, and issues registered one-cycle read or write commands to the memory. It returns read data with a one-cycle valid pulse to the winning requester, and rejects out-of-range addresses without touching memory.

---
 rtl/data_mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Shares a single-ported data memory between two requesters: a CPU
// load/store port (requester 0) and a secondary master such as a DMA or
// debug port (requester 1). Requests are sampled only in IDLE. When both
// requesters ask at once, round-robin priority picks the winner. The
// arbiter then issues one registered command cycle (CMD). A read adds a
// response cycle (RESP) in which the memory's registered read data is
// valid. Out-of-range addresses are acknowledged with an error pulse, and
// the memory is never touched for them.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous, active-low
//   req0/req1          request, held with we/addr/wdata stable until gnt
//   we0/we1            1 = write, 0 = read
//   addr0/addr1        32-bit word address
//   wdata0/wdata1      write data
//   gnt0/gnt1          one-cycle pulse: request accepted
//   err0/err1          one-cycle pulse with gnt: address out of range
//   rvalid0/rvalid1    one-cycle pulse: rdata valid for this requester
//   rdata              pass-through of mem_rdata
//   mem_write/mem_read memory command strobes
//   mem_addr           memory word address (upper bits always zero)
//   mem_wdata          memory write data
//   mem_rdata          memory read data (registered inside the memory)

module data_mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              err0,
    output logic              err1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RESP
    } state_t;

    localparam logic [31:0] INDEX_MASK = (32'd1 << DEPTH_LOG2) - 32'd1;

    state_t            state;
    logic              last_gnt;
    logic              winner;
    logic              cmd_read;

    logic              pick;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_in_range;

    // Winner selection for the IDLE sample. last_gnt resets to 1, so
    // requester 0 wins the first tie after reset.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_gnt;
        end else if (req1) begin
            pick = 1'b1;
        end
        sel_addr     = pick ? addr1  : addr0;
        sel_wdata    = pick ? wdata1 : wdata0;
        sel_we       = pick ? we1    : we0;
        sel_in_range = (sel_addr >> DEPTH_LOG2) == 32'd0;
    end

    assign rdata = mem_rdata;

    // Single FSM with registered outputs. The command strobes and the
    // gnt/err pulses are set on the edge that leaves IDLE, so they appear
    // during CMD. rvalid is set on the edge that leaves CMD, so it lines
    // up with the memory's registered read data in RESP.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            winner    <= 1'b0;
            cmd_read  <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= '0;
        end else begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner   <= pick;
                        last_gnt <= pick;
                        gnt0     <= ~pick;
                        gnt1     <= pick;
                        err0     <= ~pick & ~sel_in_range;
                        err1     <= pick & ~sel_in_range;
                        cmd_read <= sel_in_range & ~sel_we;
                        // Out-of-range requests leave the memory bus untouched.
                        if (sel_in_range) begin
                            mem_addr  <= sel_addr & INDEX_MASK;
                            mem_wdata <= sel_wdata;
                            mem_write <= sel_we;
                            mem_read  <= ~sel_we;
                        end
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_read) begin
                        rvalid0 <= ~winner;
                        rvalid1 <= winner;
                        state   <= RESP;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
